// File: rtl/i2c_passthru_arb_pkg.sv
// Shared state encoding and side encoding for the I2C passthrough bus arbiter.
package i2c_passthru_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OWN_A   = 3'd1,
        ST_OWN_B   = 3'd2,
        ST_TURN    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/i2c_passthru_pulse_timer.sv
// Down counter that reloads on i_load, decrements on i_dec pulses and sticks at zero.
module i2c_passthru_pulse_timer #(
    parameter int W    = 6,
    parameter int LOAD = 38
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_load,
    input  logic i_dec,
    output logic o_tc
);

    logic [W-1:0] r_cnt;

    // Load wins over decrement; zero is sticky until the next load.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= W'(LOAD);
        end else if (i_load) begin
            r_cnt <= W'(LOAD);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/i2c_passthru_bus_arb.sv
// Two-sided downstream I2C bus arbiter with stretch, abort and stuck-bus recovery hand-off.
// Define I2C_PASSTHRU_ARB_FAIR_EN for round-robin ties; otherwise side A wins ties.
module i2c_passthru_bus_arb
    import i2c_passthru_arb_pkg::*;
#(
    parameter int F_REF_T_BUF          = 38,
    parameter int F_REF_HOLD_MAX       = 400,
    parameter int WIDTH_F_REF_T_BUF    = 6,
    parameter int WIDTH_F_REF_HOLD_MAX = 9
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_f_ref,
    input  logic       i_req_a,
    input  logic       i_req_b,
    input  logic       i_idle,
    input  logic       i_idle_timeout,
    input  logic       i_stuck,
    output logic       o_grant_a,
    output logic       o_grant_b,
    output logic       o_hold_a,
    output logic       o_hold_b,
    output logic       o_abort_a,
    output logic       o_abort_b,
    output logic       o_rec_sel,
    output logic       o_busy,
    output logic [2:0] o_state
);

    state_t r_state;
    state_t w_next;
    logic   r_fref_d;
    logic   r_pend_a, r_pend_b;
    logic   r_abort_a, r_abort_b;
    logic   r_act;
    logic   w_fref_pulse;
    logic   w_own;
    logic   w_req_a, w_req_b;
    logic   w_sel_b;
    logic   w_grant_a, w_grant_b;
    logic   w_tbuf_load, w_tbuf_tc;
    logic   w_hold_any, w_hold_load, w_hold_cnt_tc, w_hold_tc;

    assign w_fref_pulse = i_f_ref & ~r_fref_d;
    assign w_own        = (r_state == ST_OWN_A) || (r_state == ST_OWN_B);
    // A START from the side that already owns the bus is a repeated START.
    assign w_req_a      = i_req_a & (r_state != ST_OWN_A);
    assign w_req_b      = i_req_b & (r_state != ST_OWN_B);

`ifdef I2C_PASSTHRU_ARB_FAIR_EN
    logic r_last_owner;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_last_owner <= SIDE_B;
        end else if (w_grant_a) begin
            r_last_owner <= SIDE_A;
        end else if (w_grant_b) begin
            r_last_owner <= SIDE_B;
        end
    end

    assign w_sel_b = r_pend_b & (~r_pend_a | (r_last_owner == SIDE_A));
`else
    assign w_sel_b = r_pend_b & ~r_pend_a;
`endif

    always_comb begin
        w_next      = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_tbuf_load = 1'b0;
        if (i_stuck) begin
            w_next = ST_RECOVER;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_idle && (r_pend_a || r_pend_b)) begin
                        w_tbuf_load = 1'b1;
                        if (w_sel_b) begin
                            w_next    = ST_OWN_B;
                            w_grant_b = 1'b1;
                        end else begin
                            w_next    = ST_OWN_A;
                            w_grant_a = 1'b1;
                        end
                    end
                end
                ST_OWN_A, ST_OWN_B: begin
                    if ((r_act && i_idle) || i_idle_timeout || (!r_act && w_tbuf_tc)) begin
                        w_next      = ST_TURN;
                        w_tbuf_load = 1'b1;
                    end
                end
                ST_TURN: begin
                    if (w_tbuf_tc) w_next = ST_IDLE;
                end
                ST_RECOVER: begin
                    w_next      = ST_TURN;
                    w_tbuf_load = 1'b1;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_fref_d  <= 1'b0;
            r_pend_a  <= 1'b0;
            r_pend_b  <= 1'b0;
            r_abort_a <= 1'b0;
            r_abort_b <= 1'b0;
            r_act     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_fref_d  <= i_f_ref;
            r_abort_a <= 1'b0;
            r_abort_b <= 1'b0;
            if (w_grant_a || w_grant_b) begin
                r_act <= 1'b0;
            end else if (w_own && !i_idle) begin
                r_act <= 1'b1;
            end
            // Recovery drops everything pending, including requests arriving now.
            if (i_stuck) begin
                r_abort_a <= r_pend_a | w_req_a;
                r_abort_b <= r_pend_b | w_req_b;
                r_pend_a  <= 1'b0;
                r_pend_b  <= 1'b0;
            end else begin
                if (w_grant_a) begin
                    r_pend_a <= 1'b0;
                end else if (w_hold_tc && o_hold_a) begin
                    r_pend_a  <= 1'b0;
                    r_abort_a <= 1'b1;
                end else if (w_req_a) begin
                    r_pend_a <= 1'b1;
                end
                if (w_grant_b) begin
                    r_pend_b <= 1'b0;
                end else if (w_hold_tc && o_hold_b) begin
                    r_pend_b  <= 1'b0;
                    r_abort_b <= 1'b1;
                end else if (w_req_b) begin
                    r_pend_b <= 1'b1;
                end
            end
        end
    end

    assign w_hold_any  = o_hold_a | o_hold_b;
    assign w_hold_tc   = w_hold_cnt_tc & w_hold_any;
    assign w_hold_load = ~w_hold_any | w_grant_a | w_grant_b | w_hold_tc;

    i2c_passthru_pulse_timer #(
        .W    (WIDTH_F_REF_T_BUF),
        .LOAD (F_REF_T_BUF)
    ) u_tbuf_timer (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_load (w_tbuf_load),
        .i_dec  (w_fref_pulse),
        .o_tc   (w_tbuf_tc)
    );

    i2c_passthru_pulse_timer #(
        .W    (WIDTH_F_REF_HOLD_MAX),
        .LOAD (F_REF_HOLD_MAX)
    ) u_hold_timer (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_load (w_hold_load),
        .i_dec  (w_fref_pulse & w_hold_any),
        .o_tc   (w_hold_cnt_tc)
    );

    assign o_grant_a = (r_state == ST_OWN_A);
    assign o_grant_b = (r_state == ST_OWN_B);
    assign o_hold_a  = r_pend_a & ~o_grant_a;
    assign o_hold_b  = r_pend_b & ~o_grant_b;
    assign o_abort_a = r_abort_a;
    assign o_abort_b = r_abort_b;
    assign o_rec_sel = (r_state == ST_RECOVER);
    assign o_busy    = (r_state != ST_IDLE);
    assign o_state   = r_state;

endmodule

// File: doc/i2c_passthru_bus_arb.md
# i2c_passthru_bus_arb

Arbiter sharing the single downstream I2C/SMBus segment between two upstream passthrough sides (A and B). It latches each side's START request and grants bus ownership to one side at a time. It holds the losing side's SCL low (clock stretch) until that side is granted or times out. It also hands the bus to the idle/stuck recovery logic whenever that logic reports the bus stuck.

## Interface
- `F_REF_T_BUF`, 38: i_f_ref periods of bus-free time between owners; also the window in which a new owner must start activity.
- `F_REF_HOLD_MAX`, 400: i_f_ref periods a pending side may be stretched before it is aborted.
- `WIDTH_F_REF_T_BUF`, 6: counter width, ceil(log2(F_REF_T_BUF+1)).
- `WIDTH_F_REF_HOLD_MAX`, 9: counter width, ceil(log2(F_REF_HOLD_MAX+1)).
- `i_clk` in 1: single clock; all logic on posedge.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_f_ref` in 1: timing reference; rising edge detected internally.
- `i_req_a`, `i_req_b` in 1: one-cycle START-detected pulse from side A / B.
- `i_idle` in 1: downstream bus idle (from idle/stuck detector).
- `i_idle_timeout` in 1: one-cycle pulse, bus went idle by timeout.
- `i_stuck` in 1: downstream bus stuck, recovery active.
- `o_grant_a`, `o_grant_b` out 1: side owns the downstream bus; connect passthrough.
- `o_hold_a`, `o_hold_b` out 1: stretch SCL low on that side.
- `o_abort_a`, `o_abort_b` out 1: one-cycle pulse; pending request dropped.
- `o_rec_sel` out 1: route recovery o_sda/o_scl onto the downstream bus.
- `o_busy` out 1: state is not ST_IDLE.

## Operation
- Pending flags pend_a/pend_b:
  - Set on i_req_x.
  - Cleared on grant to x, abort of x, or entry to ST_RECOVER.
  - A request from the current owner is ignored (repeated START).
- o_hold_x = pend_x & ~o_grant_x.
- States:
  - ST_IDLE: if i_stuck -> ST_RECOVER. Else, if i_idle and any pend, grant the selected side -> ST_OWN_A/ST_OWN_B. On entry to an owner state, reload t_buf timer and clear act.
  - ST_OWN_x: act set when i_idle=0. Exit to ST_TURN (reload t_buf timer) on any of: act & i_idle, i_idle_timeout, or (~act & t_buf tc). i_stuck -> ST_RECOVER.
  - ST_TURN: t_buf timer decrements per f_ref pulse. tc -> ST_IDLE. i_stuck -> ST_RECOVER.
  - ST_RECOVER: o_rec_sel=1, no grants. Pending flags are cleared with abort pulses for the sides that were pending. Requests arriving during recovery are aborted the following cycle. Exit when i_stuck=0 -> ST_TURN.
- Selection when both sides are pending: the side that is not last_owner wins. last_owner updates on every grant.
- Hold timer:
  - Reloads F_REF_HOLD_MAX while no side is waiting, and on every grant.
  - Decrements per f_ref pulse while any o_hold_x=1.
  - tc aborts every waiting side: abort pulse, pend cleared, timer reload.
- Simultaneous events:
  - i_stuck has top priority.
  - In ST_OWN_x, exit on idle beats a same-cycle i_req from the other side; the request is latched.
  - Abort and grant of the same side in one cycle: grant wins.
- Timer underflow: timers saturate at 0 and never wrap.

## Timing
- All outputs registered; 1 cycle from causing input to output.
- i_req_a in ST_IDLE with i_idle=1 -> o_grant_a high 2 cycles later (pend latch + state).
- Minimum gap between owners: F_REF_T_BUF f_ref pulses plus 2 cycles.
- Reset values: all outputs 0, state ST_IDLE, pend 0, act 0, last_owner=B, timers loaded.
- Async reset mid-ownership: grants and holds drop immediately, with no abort pulse.

## Configuration
- `I2C_PASSTHRU_ARB_FAIR_EN` defined: round-robin selection via last_owner, as above.
- Not defined: fixed priority, A always wins ties; last_owner register omitted.

## Structure
- Package `i2c_passthru_arb_pkg`: state localparams (ST_IDLE, ST_OWN_A, ST_OWN_B, ST_TURN, ST_RECOVER) and the side encoding (SIDE_A=0, SIDE_B=1).
- Sub-module `i2c_passthru_pulse_timer`: load/decrement-on-pulse/saturating down counter with tc, parameterised by width and load value. Instantiated twice: t_buf timer and hold timer.
- f_ref edge detect stays in the top module.

## Test plan
- i_req_a with i_idle=1 -> o_grant_a=1 at cycle+2; i_idle low then high -> ST_TURN; o_busy stays 1 for 38 f_ref pulses; then ST_IDLE.
- A owning, i_req_b pulse -> o_hold_b=1; A releases -> o_grant_b after 38 f_ref pulses; o_hold_b falls in the same cycle o_grant_b rises.
- i_req_a and i_req_b in the same cycle after reset -> A granted first, then B. Repeat with last_owner=A -> B granted first (with FAIR_EN); without the macro -> A both times.
- B waiting while A is active for more than 400 f_ref pulses -> o_abort_b single pulse, o_hold_b=0.
- i_stuck asserted during ST_OWN_A with B pending -> next cycle o_grant_a=0, o_rec_sel=1, o_abort_b pulse. i_stuck falls -> ST_TURN, then ST_IDLE.
- Grant with no bus activity for 38 f_ref pulses -> o_grant_a drops, state ST_TURN.
